// File: rtl/auth_initiator.sv
// Authentication initiator: builds GET_DIGESTS / GET_CERTIFICATE / CHALLENGE requests,
// drives them to the responder with timeout and retry, then validates the response.
module auth_initiator #(
    parameter int MSG_LEN        = 256,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          req_type,
    input  logic [7:0]          req_param1,
    input  logic [7:0]          req_param2,
    input  logic [MSG_LEN-33:0] req_payload,
    output logic                init_req_out,
    output logic [MSG_LEN-1:0]  auth_msg_init_out,
    input  logic                resp_req_in,
    input  logic [MSG_LEN-1:0]  auth_msg_init_in,
    output logic                Ack_out,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [7:0]          status_code,
    output logic [7:0]          resp_param1,
    output logic [7:0]          resp_param2,
    output logic [MSG_LEN-33:0] resp_payload
);

    localparam int PL = MSG_LEN - 32;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [1:0] {IDLE, WAIT, GAP, CHECK} state_t;

    state_t          state;
    logic [CW-1:0]   tmo_cnt;
    logic [RW-1:0]   retry_cnt;
    logic [7:0]      exp_type;
    logic [MSG_LEN-1:0] resp_msg;

    logic [7:0]      req_msg_type;
    logic [PL-1:0]   req_body;
    logic [7:0]      resp_version;
    logic [7:0]      resp_type;

    always_comb begin
        req_msg_type = 8'h83;
        case (req_type)
            2'd0:    req_msg_type = 8'h81;
            2'd1:    req_msg_type = 8'h82;
            default: req_msg_type = 8'h83;
        endcase
        req_body = (req_type == 2'd0) ? '0 : req_payload;
    end

    assign resp_version = resp_msg[MSG_LEN-1 -: 8];
    assign resp_type    = resp_msg[MSG_LEN-9 -: 8];

    // done, error and Ack_out are single-cycle pulses: cleared every cycle unless re-asserted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            tmo_cnt           <= '0;
            retry_cnt         <= '0;
            exp_type          <= '0;
            resp_msg          <= '0;
            init_req_out      <= 1'b0;
            auth_msg_init_out <= '0;
            Ack_out           <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            error             <= 1'b0;
            status_code       <= '0;
            resp_param1       <= '0;
            resp_param2       <= '0;
            resp_payload      <= '0;
        end else begin
            done    <= 1'b0;
            error   <= 1'b0;
            Ack_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (req_type == 2'd3) begin
                            error       <= 1'b1;
                            status_code <= 8'h05;
                        end else begin
                            auth_msg_init_out <= {8'h01, req_msg_type, req_param1, req_param2, req_body};
                            exp_type          <= {6'b0, req_type} + 8'd1;
                            init_req_out      <= 1'b1;
                            tmo_cnt           <= '0;
                            retry_cnt         <= '0;
                            busy              <= 1'b1;
                            state             <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (resp_req_in) begin
                        resp_msg     <= auth_msg_init_in;
                        init_req_out <= 1'b0;
                        Ack_out      <= 1'b1;
                        state        <= CHECK;
                    end else if (tmo_cnt == CNT_LAST) begin
                        init_req_out <= 1'b0;
                        if (retry_cnt < RETRY_MAX) begin
                            retry_cnt <= retry_cnt + 1'b1;
                            state     <= GAP;
                        end else begin
                            error       <= 1'b1;
                            status_code <= 8'h04;
                            busy        <= 1'b0;
                            state       <= IDLE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                GAP: begin
                    init_req_out <= 1'b1;
                    tmo_cnt      <= '0;
                    state        <= WAIT;
                end
                CHECK: begin
                    resp_param1  <= resp_msg[MSG_LEN-17 -: 8];
                    resp_param2  <= resp_msg[MSG_LEN-25 -: 8];
                    resp_payload <= resp_msg[PL-1:0];
                    busy         <= 1'b0;
                    state        <= IDLE;
                    // Version is checked before the ERROR type so a malformed frame is never trusted.
                    if (resp_version != 8'h01) begin
                        error       <= 1'b1;
                        status_code <= 8'h02;
                    end else if (resp_type == 8'h7F) begin
                        error       <= 1'b1;
                        status_code <= 8'h01;
                    end else if (resp_type != exp_type) begin
                        error       <= 1'b1;
                        status_code <= 8'h03;
                    end else begin
                        done        <= 1'b1;
                        status_code <= 8'h00;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
